// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sharing a bank of WIDTH JK flip-flop bits between 4 requesters.
// A granted command applies its JK op to one bit for cnt+1 consecutive clocks.
module jk_bank_arbiter #(
  parameter int WIDTH = 8,
  parameter int IW    = 3,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req_valid,
  input  logic [7:0]       req_op,
  input  logic [4*IW-1:0]  req_idx,
  input  logic [4*CW-1:0]  req_cnt,
  output logic [3:0]       req_ready,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             busy,
  output logic [1:0]       owner,
  output logic [3:0]       done,
  output logic             err
);

  typedef enum logic {IDLE, EXEC} state_t;

  localparam logic [IW:0] WLIM = (IW+1)'(WIDTH);

  state_t           state, state_next;
  logic [1:0]       ptr;
  logic [1:0]       op_r;
  logic [IW-1:0]    idx_r;
  logic [CW-1:0]    rem;
  logic [1:0]       cand;
  logic [1:0]       grant_id;
  logic             found;
  logic [3:0]       grant;
  logic             last;
  logic             in_range;
  logic [WIDTH-1:0] q_next;

  // Rotating priority: the first valid requester at or after ptr wins.
  always_comb begin
    cand     = '0;
    grant_id = '0;
    found    = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!found && req_valid[cand]) begin
        found    = 1'b1;
        grant_id = cand;
      end
    end
    grant = found ? (4'b0001 << grant_id) : '0;
  end

  assign req_ready = (state == IDLE) ? grant : '0;
  assign last      = (rem == '0);
  assign in_range  = ({1'b0, idx_r} < WLIM);
  assign busy      = (state == EXEC);
  assign q_bar     = ~q;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found) state_next = EXEC;
      EXEC:    if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bank update; clr wins over the JK update on the same edge.
  always_comb begin
    q_next = q;
    if (state == EXEC) begin
      for (int unsigned b = 0; b < WIDTH; b++) begin
        if (in_range && idx_r == IW'(b)) begin
          case (op_r)
            2'b01:   q_next[b] = 1'b0;
            2'b10:   q_next[b] = 1'b1;
            2'b11:   q_next[b] = ~q[b];
            default: q_next[b] = q[b];
          endcase
        end
      end
    end
    if (clr) q_next = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q     <= '0;
      ptr   <= '0;
      owner <= '0;
      op_r  <= '0;
      idx_r <= '0;
      rem   <= '0;
      done  <= '0;
      err   <= 1'b0;
    end else begin
      q    <= q_next;
      done <= '0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            owner <= grant_id;
            op_r  <= req_op[2*grant_id +: 2];
            idx_r <= req_idx[IW*grant_id +: IW];
            rem   <= req_cnt[CW*grant_id +: CW];
          end
        end
        EXEC: begin
          if (last) begin
            ptr         <= owner + 2'd1;
            done[owner] <= 1'b1;
            err         <= ~in_range;
          end else begin
            rem <= rem - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Bench for jk_bank_arbiter: a WIDTH=8 and a WIDTH=6 instance share one stimulus stream
// and are checked every cycle against a command-level model plus directed literal checks.
module tb_jk_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid = '0;
  logic [7:0]  req_op    = '0;
  logic [11:0] req_idx   = '0;
  logic [15:0] req_cnt   = '0;
  logic        clr       = 1'b0;

  logic [3:0] ready8, ready6, done8, done6;
  logic [7:0] q8, qb8;
  logic [5:0] q6, qb6;
  logic       busy8, busy6, err8, err6;
  logic [1:0] owner8, owner6;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  jk_bank_arbiter #(.WIDTH(8), .IW(3), .CW(4)) u_dut8 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_idx(req_idx),
    .req_cnt(req_cnt), .req_ready(ready8), .clr(clr), .q(q8), .q_bar(qb8),
    .busy(busy8), .owner(owner8), .done(done8), .err(err8)
  );

  jk_bank_arbiter #(.WIDTH(6), .IW(3), .CW(4)) u_dut6 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_idx(req_idx),
    .req_cnt(req_cnt), .req_ready(ready6), .clr(clr), .q(q6), .q_bar(qb6),
    .busy(busy6), .owner(owner6), .done(done6), .err(err6)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Command-level model: one outstanding command with a count of updates still owed.
  int         wid [2] = '{8, 6};
  logic [7:0] m_q [2];
  bit         m_busy [2];
  int         m_owner [2], m_op [2], m_idx [2], m_left [2], m_ptr [2];
  logic [3:0] m_done [2];
  bit         m_err [2];

  function automatic int pick(input int p, input logic [3:0] v);
    for (int k = 0; k < 4; k++)
      if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_q[d] = '0; m_busy[d] = 0; m_owner[d] = 0; m_ptr[d] = 0;
        m_done[d] = '0; m_err[d] = 0; m_left[d] = 0; m_op[d] = 0; m_idx[d] = 0;
      end else begin
        int g;
        m_done[d] = '0;
        m_err[d]  = 0;
        if (m_busy[d]) begin
          if (m_idx[d] < wid[d]) begin
            if (m_op[d] == 1) m_q[d][m_idx[d]] = 1'b0;
            if (m_op[d] == 2) m_q[d][m_idx[d]] = 1'b1;
            if (m_op[d] == 3) m_q[d][m_idx[d]] = ~m_q[d][m_idx[d]];
          end
          m_left[d]--;
          if (m_left[d] == 0) begin
            m_busy[d] = 0;
            m_ptr[d]  = (m_owner[d] + 1) % 4;
            m_done[d][m_owner[d]] = 1'b1;
            m_err[d]  = (m_idx[d] >= wid[d]);
          end
        end else begin
          g = pick(m_ptr[d], req_valid);
          if (g >= 0) begin
            m_busy[d]  = 1;
            m_owner[d] = g;
            m_op[d]    = int'(req_op[2*g +: 2]);
            m_idx[d]   = int'(req_idx[3*g +: 3]);
            m_left[d]  = int'(req_cnt[4*g +: 4]) + 1;
          end
        end
        if (clr) m_q[d] = '0;
      end
    end
  end

  always begin
    @(posedge clk);
    #2;
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        int         g;
        logic [7:0] mask, aq, aqb;
        logic [3:0] ardy, adone, erdy;
        logic       abusy, aerr;
        logic [1:0] aown;
        mask  = (d == 0) ? 8'hFF : 8'h3F;
        aq    = (d == 0) ? q8 : {2'b00, q6};
        aqb   = (d == 0) ? qb8 : {2'b00, qb6};
        ardy  = (d == 0) ? ready8 : ready6;
        adone = (d == 0) ? done8 : done6;
        abusy = (d == 0) ? busy8 : busy6;
        aerr  = (d == 0) ? err8 : err6;
        aown  = (d == 0) ? owner8 : owner6;
        g     = pick(m_ptr[d], req_valid);
        erdy  = (m_busy[d] || g < 0) ? 4'b0000 : (4'b0001 << g);
        chk($sformatf("model_ready[w%0d]", wid[d]), 32'(ardy), 32'(erdy));
        chk($sformatf("model_q[w%0d]", wid[d]), 32'(aq), 32'(m_q[d] & mask));
        chk($sformatf("model_qbar[w%0d]", wid[d]), 32'(aqb), 32'(~m_q[d] & mask));
        chk($sformatf("model_busy[w%0d]", wid[d]), 32'(abusy), 32'(m_busy[d]));
        chk($sformatf("model_done[w%0d]", wid[d]), 32'(adone), 32'(m_done[d]));
        chk($sformatf("model_err[w%0d]", wid[d]), 32'(aerr), 32'(m_err[d]));
        if (m_busy[d]) chk($sformatf("model_owner[w%0d]", wid[d]), 32'(aown), 32'(m_owner[d]));
      end
    end
  end

  task automatic drive(input int i, input int op, input int idx, input int cnt);
    req_valid[i]       = 1'b1;
    req_op[2*i +: 2]   = 2'(op);
    req_idx[3*i +: 3]  = 3'(idx);
    req_cnt[4*i +: 4]  = 4'(cnt);
  endtask

  // Issue from IDLE at a falling edge; returns on the falling edge where done is high.
  task automatic run_cmd(input int i, input int op, input int idx, input int cnt);
    drive(i, op, idx, cnt);
    @(negedge clk);
    req_valid = '0;
    repeat (cnt + 1) @(negedge clk);
    chk("run_done8", 32'(done8), 32'(4'b0001 << i));
    chk("run_done6", 32'(done6), 32'(4'b0001 << i));
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_q", 32'(q8), 32'h00);
    chk("reset_qbar", 32'(qb8), 32'hFF);
    chk("reset_busy", 32'(busy8), 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: mid-sim async reset, then a single set on bit 3
    #3 rst = 1'b1;
    #1 chk("t1_rst_done", 32'(done8), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 2, 3, 0);
    #1 chk("t1_ready", 32'(ready8), 32'h1);
    @(negedge clk);
    req_valid = '0;
    chk("t1_busy", 32'(busy8), 32'h1);
    chk("t1_owner", 32'(owner8), 32'h0);
    @(negedge clk);
    chk("t1_q", 32'(q8), 32'h08);
    chk("t1_done", 32'(done8), 32'h1);
    chk("t1_idle", 32'(busy8), 32'h0);
    @(negedge clk);
    chk("t1_done_gone", 32'(done8), 32'h0);

    // 2: five toggles on bit 0 by requester 1
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    drive(1, 3, 0, 4);
    @(negedge clk);
    req_valid = '0;
    for (int u = 1; u <= 5; u++) begin
      @(negedge clk);
      chk($sformatf("t2_q0_%0d", u), 32'(q8[0]), 32'(u % 2));
    end
    chk("t2_done", 32'(done8), 32'h2);
    chk("t2_idle", 32'(busy8), 32'h0);

    // 3: round-robin with all four requesters valid
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) drive(i, 2, i, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("t3_owner_%0d", k), 32'(owner8), 32'(k % 4));
      if (k == 4) req_valid = '0;
      @(negedge clk);
      chk($sformatf("t3_done_%0d", k), 32'(done8), 32'(4'b0001 << (k % 4)));
      if (k == 0) chk("t3_ready_in_done", 32'(ready8), 32'h2);
      if (k == 3) chk("t3_q", 32'(q8), 32'h0F);
    end

    // 4: reset during a long toggle command
    drive(2, 3, 7, 15);
    @(negedge clk);
    req_valid = '0;
    chk("t4_owner", 32'(owner8), 32'h2);
    repeat (3) @(negedge clk);
    chk("t4_q_mid", 32'(q8), 32'h8F);
    #3 rst = 1'b1;
    #1;
    chk("t4_q", 32'(q8), 32'h00);
    chk("t4_busy", 32'(busy8), 32'h0);
    chk("t4_done", 32'(done8), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0);
    drive(3, 0, 0, 0);
    #1 chk("t4_ready", 32'(ready8), 32'h1);
    req_valid = '0;
    @(negedge clk);

    // 5: out-of-range index on the 6-bit bank, then clr racing a set
    drive(3, 2, 6, 1);
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    chk("t5_err6", 32'(err6), 32'h1);
    chk("t5_done6", 32'(done6), 32'h8);
    chk("t5_q6", 32'(q6), 32'h00);
    chk("t5_err8", 32'(err8), 32'h0);
    chk("t5_q8", 32'(q8), 32'h40);
    @(negedge clk);
    chk("t5_err6_gone", 32'(err6), 32'h0);
    drive(0, 2, 2, 1);
    @(negedge clk);
    req_valid = '0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("t5_clr_q", 32'(q8), 32'h00);
    @(negedge clk);
    chk("t5_set_q", 32'(q8), 32'h04);
    chk("t5_set_done", 32'(done8), 32'h1);

    // 6: preload, reset op, hold op, and a full-length toggle run
    for (int b = 0; b < 8; b++) run_cmd(0, 2, b, 0);
    chk("t6_ff", 32'(q8), 32'hFF);
    chk("t6_ff6", 32'(q6), 32'h3F);
    run_cmd(0, 1, 5, 0);
    chk("t6_df", 32'(q8), 32'hDF);
    chk("t6_df6", 32'(q6), 32'h1F);
    drive(0, 0, 4, 3);
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    chk("t6_hold_busy", 32'(busy8), 32'h1);
    @(negedge clk);
    chk("t6_hold_end", 32'(busy8), 32'h0);
    chk("t6_hold_done", 32'(done8), 32'h1);
    chk("t6_hold_q", 32'(q8), 32'hDF);
    run_cmd(1, 3, 1, 15);
    chk("t6_16toggles", 32'(q8), 32'hDF);
    chk("t6_qbar", 32'(qb8), 32'h20);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jk_bank_arbiter.md
Name: jk_bank_arbiter

Overview:
Round-robin controller that shares a bank of WIDTH JK flip-flop bits between 4 requesters.
- Each requester issues a command: target bit index, JK operation and repeat count.
- The arbiter grants one requester at a time and sequences the operation onto the selected bit for cnt+1 consecutive clocks.
- The bank outputs Q/Q_bar feed downstream status and flag logic.

Parameters:
- WIDTH, 8: number of JK bits in the bank.
- IW, 3: index width; must satisfy 2^IW >= WIDTH.
- CW, 4: repeat-count width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  4  per-requester command valid.
- req_op  input  8  2 bits per requester, requester i at [2i+1:2i]. Encoding: 00 hold (J=0,K=0), 01 reset (J=0,K=1), 10 set (J=1,K=0), 11 toggle (J=1,K=1).
- req_idx  input  4*IW  target bit index per requester, requester i at [IW*i+IW-1:IW*i].
- req_cnt  input  4*CW  repeat count per requester; the op is applied cnt+1 times.
- req_ready  output  4  one-hot accept, combinational.
- clr  input  1  synchronous clear of the whole bank.
- q  output  WIDTH  bank state.
- q_bar  output  WIDTH  always ~q.
- busy  output  1  high while in EXEC.
- owner  output  2  requester currently being executed; valid when busy.
- done  output  4  one-cycle pulse to the owner after its last update.
- err  output  1  one-cycle pulse coincident with done when the latched idx >= WIDTH.

Behaviour:
- Reset (async, any time, including mid-command):
  - q=0, q_bar=all ones, state=IDLE, ptr=0, busy=0, owner=0, done=0, err=0.
  - Any in-flight command is dropped without a done pulse.
- States: IDLE, EXEC.
- Arbitration:
  - Round-robin over req_valid, starting at ptr: search ptr, ptr+1, ... mod 4.
  - grant is one-hot.
  - req_ready = grant when state==IDLE, else 0.
  - req_ready depends on req_valid combinationally; req_valid must not depend on req_ready.
- IDLE:
  - Transfer occurs on an edge where req_valid[i] & req_ready[i].
  - At that edge: latch op, idx, cnt of the winner; owner<=i; rem<=cnt; state<=EXEC.
  - No bank update at the accept edge.
  - If no valid request, stay in IDLE; ptr unchanged.
- EXEC (busy=1), at each edge:
  - Apply op to bit idx using the JK rule: 00 hold, 01 Q<=0, 10 Q<=1, 11 Q<=~Q.
  - If rem==0: state<=IDLE, ptr<=owner+1 mod 4, done[owner]<=1 for exactly the next cycle; err likewise if idx>=WIDTH.
  - Otherwise rem<=rem-1.
- Out-of-range idx (idx>=WIDTH): no bank bit changes; the sequence still runs to completion.
- Timing:
  - A command occupies cnt+2 cycles: 1 accept + cnt+1 execute.
  - The first q change is visible after the first edge following the accept edge.
  - The next accept can occur in the cycle done is high. Back-to-back commands therefore have no idle gap beyond the accept cycle.
- clr:
  - At an edge with clr=1, q<=0, overriding the EXEC update on that same edge.
  - The FSM, rem and done timing are unaffected; the command continues on the cleared bank.
- Holding inputs:
  - Requester inputs are sampled only at the accept edge.
  - Changes during EXEC have no effect.
  - A requester whose valid stays high after its done is re-granted only after the other valid requesters have been served (fairness).
- Widths: rem is CW bits. cnt = 2^CW - 1 gives 2^CW updates; no wrap beyond that.
- No combinational path from any input to q, q_bar, busy, owner, done or err.

Test Plan:
1. Reset and accept: assert rst mid-sim, release; req_valid=0001, op=10, idx=3, cnt=0.
   - req_ready=0001 in the first cycle after release.
   - q=8'h08 after 2 edges; done=0001 for 1 cycle; busy high for 1 cycle.
2. Toggle repeat: q=0, requester 1 op=11, idx=0, cnt=4 (5 toggles).
   - q[0] sequence 1,0,1,0,1.
   - done[1] pulses on the cycle after the 5th update.
   - Total 6 cycles from accept to IDLE.
3. Round-robin: all 4 valid continuously, each op=10 with idx=i, cnt=0.
   - Grant order 0,1,2,3,0.
   - q=8'h0F after the first round.
   - Each requester gets exactly one grant per 4 commands.
4. Contention plus reset mid-EXEC: requester 2 op=11, idx=7, cnt=15; assert rst after 3 updates.
   - q=0, busy=0, no done pulse.
   - After release, ptr=0, so requester 0 wins if valid.
5. clr and out-of-range: WIDTH=6, requester 3 op=10, idx=6, cnt=1.
   - q unchanged; err and done[3] pulse together after 2 updates.
   - Separately, clr asserted during a set command on idx 2 clears q on that edge; the next update sets q=8'h04.
6. Hold and reset ops:
   - Preload q=8'hFF via set commands; op=01 on idx 5 gives q=8'hDF.
   - op=00 cnt=3 leaves q=8'hDF and takes 5 cycles.
   - q_bar always equals ~q.
